multicycle_main_control: RTL
============================

# multicycle_main_control

Multicycle main control FSM for the datapath. Decodes the 6-bit instruction opcode over several cycles and drives every datapath enable/select, including the 3-bit ALU operation class consumed by `alu_control_unit`. Sits directly upstream of `alu_control_unit`, between the instruction register and the datapath muxes. Stalls in memory states on a memory-ready handshake.

## Interface
Parameters:
- none. Encodings are fixed constants in the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  instruction `[31:26]` from the instruction register. Sampled only in DECODE.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero (beq).
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_read`  out  1  memory read request.
- `mem_write`  out  1  memory write request.
- `ir_write`  out  1  instruction register load.
- `mem_to_reg`  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pc_source`  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_op`  out  3  ALU operation class to `alu_control_unit`.
- `illegal_op`  out  1  one-cycle pulse on an unrecognised opcode.
- `state`  out  4  current state, for debug and verification.

## Operation
- Opcodes: RTYPE = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000, SLTI = 001010.
- `alu_op` classes:
  - ALUOP_RTYPE = 000: use `funct`.
  - ALUOP_SUB = 001: beq compare.
  - ALUOP_SLT = 010: slti.
  - ALUOP_ADD = 011: PC increment, address calculation, addi.
- States and the outputs asserted in each. Any output not listed is 0; `alu_op` defaults to ALUOP_ADD.
  - FETCH: `mem_read`, `alu_src_b` = 01, `pc_source` = 00. When `mem_ready` = 1, also assert `ir_write` and `pc_write` and go to DECODE. Otherwise stay in FETCH with `ir_write` and `pc_write` held at 0.
  - DECODE: `alu_src_b` = 11 (branch target into ALUOut). Next state:
    - LW or SW → MEMADR
    - RTYPE → EXEC
    - BEQ → BRANCH
    - J → JUMP
    - ADDI → IEXEC
    - SLTI → SEXEC
    - anything else → FETCH, with `illegal_op` = 1.
  - MEMADR: `alu_src_a` = 1, `alu_src_b` = 10. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD: `mem_read`, `i_or_d`. Go to MEMWB on `mem_ready`; otherwise hold.
  - MEMWB: `reg_write`, `mem_to_reg`, `reg_dst` = 0. Go to FETCH.
  - MEMWR: `mem_write`, `i_or_d`. Go to FETCH on `mem_ready`; otherwise hold.
  - EXEC: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = ALUOP_RTYPE. Go to RWB.
  - RWB: `reg_write`, `reg_dst` = 1. Go to FETCH.
  - BRANCH: `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = ALUOP_SUB, `pc_write_cond`, `pc_source` = 01. Go to FETCH.
  - JUMP: `pc_write`, `pc_source` = 10. Go to FETCH.
  - IEXEC / SEXEC: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = ALUOP_ADD / ALUOP_SLT. Go to IWB.
  - IWB: `reg_write`, `reg_dst` = 0. Go to FETCH.
- All outputs are decoded combinationally from the current state (Moore). Exceptions: FETCH `ir_write`/`pc_write` and DECODE `illegal_op`, which are qualified by inputs.
- Any unreachable state encoding goes to FETCH on the next clock.

## Timing
- Reset: while `rst` = 1, state = FETCH immediately (asynchronous). All outputs then equal the FETCH values with `mem_ready` = 0:
  - `mem_read` = 1, `alu_src_b` = 01, `alu_op` = 011
  - everything else 0.
- Reset asserted mid-instruction, including mid memory stall: the instruction is abandoned with no further write. The first cycle after release is FETCH.
- Cycles per instruction, with `mem_ready` high on first request:
  - LW = 5
  - SW, RTYPE, ADDI, SLTI = 4
  - BEQ, J = 3
  - illegal = 2
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. `mem_read`/`mem_write` are held steady throughout the stall.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.
- `opcode` is used only in DECODE and MEMADR. The IR is stable then, because `ir_write` fires only in FETCH.

## Structure
- Shared package `ctrl_pkg`:
  - opcode localparams
  - ALUOP_* constants, shared with `alu_control_unit` callers
  - `alu_src_b` and `pc_source` encodings
  - state encodings (4-bit)
- Single module, no sub-modules. Structure: one state register, one next-state block, one output decode block.

## Test plan
- Reset, then release with `mem_ready` = 1 → FETCH: `mem_read` = 1, `ir_write` = 1, `pc_write` = 1, `alu_op` = 011. Next cycle `state` = DECODE.
- opcode 100011, `mem_ready` always 1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. In MEMWB: `reg_write` = 1, `mem_to_reg` = 1.
- opcode 000000 → EXEC has `alu_op` = 000, `alu_src_a` = 1, `alu_src_b` = 00. RWB has `reg_dst` = 1, `reg_write` = 1. Total 4 cycles.
- opcode 000100 → BRANCH has `alu_op` = 001, `pc_write_cond` = 1, `pc_source` = 01. opcode 001010 → SEXEC has `alu_op` = 010.
- opcode 101011 with `mem_ready` low for 3 cycles in MEMWR → `mem_write` held high for 4 cycles, no `reg_write`, then FETCH.
- opcode 111111 → `illegal_op` pulses for 1 cycle in DECODE, then FETCH. Separately, assert `rst` in MEMRD → state = FETCH immediately, with no `reg_write` pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: opcodes, ALU operation
// classes, datapath mux selects and the main control state codes.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // Operation classes handed to alu_control_unit
    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_SEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

endpackage

// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM: Moore decode of datapath controls from the
// current state, with memory-ready stalls in FETCH, MEMRD and MEMWR.
module multicycle_main_control
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t cur_state;
    state_t nxt_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_state <= S_FETCH;
        else
            cur_state <= nxt_state;
    end

    assign state = cur_state;

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXEC;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI:      nxt_state = S_IEXEC;
                    OP_SLTI:      nxt_state = S_SEXEC;
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)
                    nxt_state = S_MEMRD;
                else if (opcode == OP_SW)
                    nxt_state = S_MEMWR;
                else
                    nxt_state = S_FETCH;
            end
            S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt_state = S_RWB;
            S_IEXEC,
            S_SEXEC:  nxt_state = S_IWB;
            default:  nxt_state = S_FETCH;
        endcase
    end

    // Only FETCH's loads and DECODE's illegal flag look at inputs; the rest is pure Moore
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        illegal_op    = 1'b0;
        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
                    OP_J, OP_ADDI, OP_SLTI: illegal_op = 1'b0;
                    default:                illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_SEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_SLT;
            end
            S_IWB:   reg_write = 1'b1;
            default: ;
        endcase
    end

endmodule
